led_status_arbiter: RTL and testbench
=====================================

# led_status_arbiter

Shares a single board LED between several status sources. Each requester owns a blink code: requester i is shown as i+1 pulses followed by a gap. The block arbitrates among active requests by fixed priority and sequences the ON/OFF/GAP phases on a millisecond timebase. With no request pending it drives an optional heartbeat toggle. It sits beside the LED blinker as the controller that decides what the shared LED pin shows.

## Interface
- CLOCK_FREQ_MHZ, 250: clock frequency, used only to derive the TICK_CYCLES default.
- TICK_CYCLES, CLOCK_FREQ_MHZ*1000: clock cycles per 1 ms tick; must be ≥1 (bench overrides to small values).
- NUM_REQ, 4: number of requesters, 1..8.
- ON_MS, 200: LED-on duration per pulse, in ms; must be ≥1.
- OFF_MS, 200: LED-off duration between pulses, in ms; must be ≥1.
- GAP_MS, 1000: LED-off duration after the last pulse, in ms; must be ≥1.
- HB_MS, 500: idle heartbeat half-period in ms; 0 disables the heartbeat (LED held off in idle).
- CLK  in  1  single clock, all logic on rising edge.
- RESET  in  1  synchronous, active-high reset.
- REQ  in  NUM_REQ  level requests; bit 0 has highest priority.
- GRANT  out  NUM_REQ  registered one-hot index of the code being displayed; 0 when idle.
- BUSY  out  1  high whenever state ≠ IDLE.
- LED_OUT  out  1  registered LED drive, 1 = lit.

## Operation
- States: IDLE, ON, OFF, GAP. Registers: state, GRANT, code (1..NUM_REQ), pulse_cnt, prescaler (0..TICK_CYCLES-1), ms_cnt, hb.
- Timebase: the prescaler counts cycles and wraps at TICK_CYCLES-1, producing a 1 ms tick. ms_cnt counts ticks. Both clear on every state transition, so phase durations are exact multiples of TICK_CYCLES. Counter widths are clogb2 of the largest terminal value.
- IDLE:
  - If any REQ bit is high, grant the lowest set index i: GRANT=1<<i, code=i+1, pulse_cnt=0, go to ON.
  - Otherwise stay in IDLE. If HB_MS>0, hb toggles every HB_MS ms. LED_OUT=hb.
- ON: LED_OUT=1. After ON_MS ms, go to OFF and increment pulse_cnt.
- OFF: LED_OUT=0. After OFF_MS ms, go to GAP if pulse_cnt==code, else go to ON.
- GAP: LED_OUT=0. After GAP_MS ms, go to IDLE and clear GRANT.
- Entering IDLE clears hb and the heartbeat timers.
- Once granted, a sequence always runs to completion. REQ changes are ignored until IDLE, including deassertion of the granted bit and assertion of a higher-priority bit.
- Simultaneous requests: only the lowest index is served. Others are served on later IDLE passes if still asserted. A persistently high bit 0 starves the rest; this is by design.
- Reset (RESET=1 at any edge, including mid-sequence): state=IDLE, GRANT=0, BUSY=0, LED_OUT=0, hb=0, all counters 0.

## Timing
- Let T=TICK_CYCLES. REQ is sampled high at edge k in IDLE. At edge k+1, GRANT, BUSY and LED_OUT=1 all take effect together.
- ON phase lasts ON_MS*T cycles. OFF lasts OFF_MS*T. GAP lasts GAP_MS*T.
- Sequence length for index i, from GRANT rise to GRANT fall: (i+1)*(ON_MS+OFF_MS)*T + GAP_MS*T cycles.
- At least one IDLE cycle separates consecutive sequences, with LED_OUT=0 in it. Repeat period = sequence length + 1.
- Heartbeat: the first toggle comes HB_MS*T cycles after IDLE entry, then every HB_MS*T cycles.
- Outputs are glitch-free and registered. There are no combinational paths from REQ to any output.

## Test plan
Parameters: T=4, NUM_REQ=4, ON_MS=2, OFF_MS=1, GAP_MS=3, HB_MS=5.
- Reset: hold RESET 3 cycles -> LED_OUT=0, GRANT=0, BUSY=0. After release with REQ=0, LED_OUT rises at cycle 20, falls at 40, repeating.
- Single request: REQ=4'b0100 pulsed for 1 cycle -> GRANT=4'b0100 next edge. LED shows 3×(8 high, 4 low), then 12 low. GRANT clears 48 cycles after rising.
- Priority: REQ=4'b1010 held -> GRANT=4'b0010, 2 pulses (36 cycles). Drop bit 1 during the sequence -> after 1 IDLE cycle, GRANT=4'b1000 with 4 pulses (60 cycles).
- Persistent request: REQ=4'b0001 held -> 8 cycles LED high per pulse, GRANT high 24 cycles, period 25 cycles. Heartbeat never toggles.
- Reset mid-sequence: assert RESET during the 2nd ON of code 3 -> next edge LED_OUT=0, GRANT=0, BUSY=0. After release with REQ still set, a fresh sequence starts from pulse 1.
- HB_MS=0 rerun of reset test: LED_OUT stays 0 for 200 idle cycles.

Source files
------------

// File: rtl/led_status_arbiter.sv
// Purpose: shares one board LED between NUM_REQ status sources, showing requester i as
//          i+1 ON/OFF pulses followed by a GAP; idle shows an optional heartbeat.
// Latency: outputs update on the edge after REQ is seen in IDLE; no back-pressure, REQ is a
//          level that stays asserted until served, and a started sequence always completes.
//
// Ports:
//   CLK      single clock, all logic on the rising edge
//   RESET    synchronous active-high reset
//   REQ      level requests, bit 0 has highest priority
//   GRANT    registered one-hot index of the code being shown, 0 when idle
//   BUSY     registered, high whenever a sequence is in progress
//   LED_OUT  registered LED drive, 1 = lit
module led_status_arbiter #(
  parameter int CLOCK_FREQ_MHZ = 250,
  parameter int TICK_CYCLES    = CLOCK_FREQ_MHZ * 1000,
  parameter int NUM_REQ        = 4,
  parameter int ON_MS          = 200,
  parameter int OFF_MS         = 200,
  parameter int GAP_MS         = 1000,
  parameter int HB_MS          = 500
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic [NUM_REQ-1:0] REQ,
  output logic [NUM_REQ-1:0] GRANT,
  output logic               BUSY,
  output logic               LED_OUT
);

  // Millisecond counter is sized for the longest phase of any kind.
  localparam int MS_MAX_A = (ON_MS > OFF_MS) ? ON_MS : OFF_MS;
  localparam int MS_MAX_B = (GAP_MS > HB_MS) ? GAP_MS : HB_MS;
  localparam int MS_MAX   = (MS_MAX_A > MS_MAX_B) ? MS_MAX_A : MS_MAX_B;
  localparam int MS_W     = $clog2(MS_MAX + 1);
  localparam int PS_W     = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam int CODE_W   = $clog2(NUM_REQ + 1);

  localparam logic [PS_W-1:0] PS_LAST  = PS_W'(TICK_CYCLES - 1);
  localparam logic [MS_W-1:0] ON_LAST  = MS_W'(ON_MS - 1);
  localparam logic [MS_W-1:0] OFF_LAST = MS_W'(OFF_MS - 1);
  localparam logic [MS_W-1:0] GAP_LAST = MS_W'(GAP_MS - 1);
  localparam logic [MS_W-1:0] HB_LAST  = MS_W'((HB_MS > 0) ? HB_MS - 1 : 0);
  localparam bit              HB_EN    = (HB_MS > 0);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_OFF  = 2'd2,
    ST_GAP  = 2'd3
  } state_t;

  state_t              state, state_nxt;
  logic [NUM_REQ-1:0]  grant_nxt;
  logic [CODE_W-1:0]   code, code_nxt;
  logic [CODE_W-1:0]   pulse_cnt, pulse_nxt;
  logic [PS_W-1:0]     prescaler, ps_nxt;
  logic [MS_W-1:0]     ms_cnt, ms_nxt;
  logic                hb, hb_nxt;
  logic                led_nxt;
  logic                tick;

  assign tick = (prescaler == PS_LAST);

  always_comb begin
    state_nxt = state;
    grant_nxt = GRANT;
    code_nxt  = code;
    pulse_nxt = pulse_cnt;
    hb_nxt    = hb;
    ps_nxt    = tick ? '0 : prescaler + PS_W'(1);
    ms_nxt    = tick ? ms_cnt + MS_W'(1) : ms_cnt;
    led_nxt   = 1'b0;

    case (state)
      ST_IDLE: begin
        if (|REQ) begin
          state_nxt = ST_ON;
          pulse_nxt = '0;
          // Scan high to low so the lowest set index is the one that sticks.
          for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (REQ[i]) begin
              grant_nxt    = '0;
              grant_nxt[i] = 1'b1;
              code_nxt     = CODE_W'(i + 1);
            end
          end
        end else if (tick && (!HB_EN || ms_cnt == HB_LAST)) begin
          // Heartbeat half-period elapsed; with the heartbeat disabled the
          // ms counter is simply held at zero and hb never changes.
          ms_nxt = '0;
          hb_nxt = hb ^ HB_EN;
        end
      end
      ST_ON: begin
        if (tick && ms_cnt == ON_LAST) begin
          state_nxt = ST_OFF;
          pulse_nxt = pulse_cnt + CODE_W'(1);
        end
      end
      ST_OFF: begin
        if (tick && ms_cnt == OFF_LAST) begin
          state_nxt = (pulse_cnt == code) ? ST_GAP : ST_ON;
        end
      end
      ST_GAP: begin
        if (tick && ms_cnt == GAP_LAST) begin
          state_nxt = ST_IDLE;
          grant_nxt = '0;
          hb_nxt    = 1'b0;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase

    // Every phase starts on a clean timebase so durations are exact tick multiples.
    if (state_nxt != state) begin
      ps_nxt = '0;
      ms_nxt = '0;
    end

    case (state_nxt)
      ST_ON:   led_nxt = 1'b1;
      ST_IDLE: led_nxt = hb_nxt;
      default: led_nxt = 1'b0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state     <= ST_IDLE;
      GRANT     <= '0;
      BUSY      <= 1'b0;
      LED_OUT   <= 1'b0;
      code      <= '0;
      pulse_cnt <= '0;
      prescaler <= '0;
      ms_cnt    <= '0;
      hb        <= 1'b0;
    end else begin
      state     <= state_nxt;
      GRANT     <= grant_nxt;
      BUSY      <= (state_nxt != ST_IDLE);
      LED_OUT   <= led_nxt;
      code      <= code_nxt;
      pulse_cnt <= pulse_nxt;
      prescaler <= ps_nxt;
      ms_cnt    <= ms_nxt;
      hb        <= hb_nxt;
    end
  end

endmodule

// File: tb/tb_led_status_arbiter.sv
// Purpose: self-checking bench for led_status_arbiter, one heartbeat-enabled and one
//          heartbeat-disabled instance driven by the same inputs.
// Latency: expected outputs come from a sequence-level model (cycles since grant / idle).
// Backpressure: none; REQ and RESET are driven 1 time unit after each rising edge.
module tb_led_status_arbiter;

  localparam int T   = 4;
  localparam int NR  = 4;
  localparam int ON  = 2;
  localparam int OFF = 1;
  localparam int GAP = 3;
  localparam int HB  = 5;
  localparam int P   = (ON + OFF) * T;

  logic          CLK   = 1'b0;
  logic          RESET = 1'b1;
  logic [NR-1:0] REQ   = '0;
  logic [NR-1:0] GRANT, grant_nohb;
  logic          BUSY, busy_nohb;
  logic          LED_OUT, led_nohb;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 CLK = ~CLK;

  led_status_arbiter #(
    .CLOCK_FREQ_MHZ(250), .TICK_CYCLES(T), .NUM_REQ(NR),
    .ON_MS(ON), .OFF_MS(OFF), .GAP_MS(GAP), .HB_MS(HB)
  ) dut (
    .CLK(CLK), .RESET(RESET), .REQ(REQ),
    .GRANT(GRANT), .BUSY(BUSY), .LED_OUT(LED_OUT)
  );

  led_status_arbiter #(
    .CLOCK_FREQ_MHZ(250), .TICK_CYCLES(T), .NUM_REQ(NR),
    .ON_MS(ON), .OFF_MS(OFF), .GAP_MS(GAP), .HB_MS(0)
  ) dut_nohb (
    .CLK(CLK), .RESET(RESET), .REQ(REQ),
    .GRANT(grant_nohb), .BUSY(busy_nohb), .LED_OUT(led_nohb)
  );

  // ---------------- reference model ----------------
  // A sequence for index i is a fixed waveform of seq_len(i) cycles starting at the
  // grant edge; idle shows hb = floor(cycles_since_idle_entry / (HB*T)) mod 2.
  function automatic int seq_len(int i);
    return (i + 1) * P + GAP * T;
  endfunction

  function automatic int lowest(logic [NR-1:0] r);
    for (int i = 0; i < NR; i++) if (r[i]) return i;
    return 0;
  endfunction

  bit m_in_seq = 1'b0;
  int m_idx    = 0;
  int m_t      = 0;
  int m_idle_t = 0;

  always @(posedge CLK) begin
    if (RESET) begin
      m_in_seq <= 1'b0;
      m_t      <= 0;
      m_idle_t <= 0;
    end else if (m_in_seq) begin
      if (m_t + 1 == seq_len(m_idx)) begin
        m_in_seq <= 1'b0;
        m_idle_t <= 0;
      end else begin
        m_t <= m_t + 1;
      end
    end else if (REQ != '0) begin
      m_in_seq <= 1'b1;
      m_idx    <= lowest(REQ);
      m_t      <= 0;
    end else begin
      m_idle_t <= m_idle_t + 1;
    end
  end

  logic [NR-1:0] exp_grant;
  logic          exp_led, exp_led_nohb;
  logic [13:0]   obs_vec, exp_vec;

  always_comb begin
    exp_grant    = '0;
    exp_led      = 1'b0;
    exp_led_nohb = 1'b0;
    if (m_in_seq) begin
      exp_grant    = NR'(1) << m_idx;
      exp_led      = (m_t < (m_idx + 1) * P) && ((m_t % P) < ON * T);
      exp_led_nohb = exp_led;
    end else begin
      exp_led = ((m_idle_t / (HB * T)) % 2) == 1;
    end
  end

  assign obs_vec = {GRANT, BUSY, LED_OUT, grant_nohb, busy_nohb, led_nohb};
  assign exp_vec = {exp_grant, m_in_seq, exp_led, exp_grant, m_in_seq, exp_led_nohb};

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    int rise_at, fall_at, nohb_high;
    RESET = 1'b1;
    REQ   = '0;
    for (int c = 0; c < 3; c++) begin
      step();
      n_checks++;
      if (obs_vec !== 14'b0) begin
        n_fail++;
        $display("FAIL reset_hold cyc=%0d got=%b want=%b", c, obs_vec, 14'b0);
      end
    end
    RESET     = 1'b0;
    rise_at   = -1;
    fall_at   = -1;
    nohb_high = 0;
    for (int c = 1; c <= 200; c++) begin
      step();
      n_checks++;
      if (obs_vec !== exp_vec) begin
        n_fail++;
        $display("FAIL reset_idle cyc=%0d got=%b want=%b", c, obs_vec, exp_vec);
      end
      if (rise_at < 0 && LED_OUT === 1'b1) rise_at = c;
      if (rise_at >= 0 && fall_at < 0 && LED_OUT === 1'b0) fall_at = c;
      if (led_nohb !== 1'b0) nohb_high++;
    end
    n_checks++;
    if (rise_at !== 20) begin
      n_fail++;
      $display("FAIL hb_rise got=%0d want=20", rise_at);
    end
    n_checks++;
    if (fall_at !== 40) begin
      n_fail++;
      $display("FAIL hb_fall got=%0d want=40", fall_at);
    end
    n_checks++;
    if (nohb_high !== 0) begin
      n_fail++;
      $display("FAIL nohb_idle_led got=%0d high cycles want=0", nohb_high);
    end
  endtask

  task automatic test_single();
    int n, pulses;
    logic prev;
    REQ = 4'b0100;
    step();
    REQ = '0;
    n_checks++;
    if ({GRANT, BUSY, LED_OUT} !== {4'b0100, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL single_grant got=%b want=%b", {GRANT, BUSY, LED_OUT}, 6'b010011);
    end
    n = 0; pulses = 1; prev = LED_OUT;
    do begin
      step();
      n++;
      n_checks++;
      if (obs_vec !== exp_vec) begin
        n_fail++;
        $display("FAIL single_seq cyc=%0d got=%b want=%b", n, obs_vec, exp_vec);
      end
      if (LED_OUT === 1'b1 && prev === 1'b0) pulses++;
      prev = LED_OUT;
    end while (GRANT === 4'b0100 && n < 200);
    n_checks++;
    if (n !== 48) begin
      n_fail++;
      $display("FAIL single_len got=%0d want=48", n);
    end
    n_checks++;
    if (pulses !== 3) begin
      n_fail++;
      $display("FAIL single_pulses got=%0d want=3", pulses);
    end
  endtask

  task automatic test_priority();
    int n;
    REQ = 4'b1010;
    step();
    n_checks++;
    if (GRANT !== 4'b0010) begin
      n_fail++;
      $display("FAIL prio_first got=%b want=0010", GRANT);
    end
    n = 0;
    do begin
      step();
      n++;
      n_checks++;
      if (obs_vec !== exp_vec) begin
        n_fail++;
        $display("FAIL prio_seq1 cyc=%0d got=%b want=%b", n, obs_vec, exp_vec);
      end
      if (n == 10) REQ = 4'b1000;
    end while (GRANT === 4'b0010 && n < 200);
    n_checks++;
    if (n !== 36) begin
      n_fail++;
      $display("FAIL prio_len1 got=%0d want=36", n);
    end
    n_checks++;
    if ({GRANT, BUSY, LED_OUT} !== 6'b0) begin
      n_fail++;
      $display("FAIL prio_idle_gap got=%b want=%b", {GRANT, BUSY, LED_OUT}, 6'b0);
    end
    step();
    REQ = '0;
    n_checks++;
    if (GRANT !== 4'b1000) begin
      n_fail++;
      $display("FAIL prio_second got=%b want=1000", GRANT);
    end
    n = 0;
    do begin
      step();
      n++;
      n_checks++;
      if (obs_vec !== exp_vec) begin
        n_fail++;
        $display("FAIL prio_seq2 cyc=%0d got=%b want=%b", n, obs_vec, exp_vec);
      end
    end while (GRANT === 4'b1000 && n < 300);
    n_checks++;
    if (n !== 60) begin
      n_fail++;
      $display("FAIL prio_len2 got=%0d want=60", n);
    end
  endtask

  task automatic test_persistent();
    int n, hi, lo, led_hi;
    REQ = 4'b0001;
    n = 0;
    do begin
      step();
      n++;
    end while (GRANT !== 4'b0001 && n < 100);
    for (int s = 0; s < 3; s++) begin
      hi = 0; led_hi = 0;
      while (GRANT === 4'b0001 && hi < 100) begin
        if (LED_OUT === 1'b1) led_hi++;
        step();
        hi++;
        n_checks++;
        if (obs_vec !== exp_vec) begin
          n_fail++;
          $display("FAIL persist_seq s=%0d cyc=%0d got=%b want=%b", s, hi, obs_vec, exp_vec);
        end
      end
      n_checks++;
      if (hi !== 24 || led_hi !== 8) begin
        n_fail++;
        $display("FAIL persist_len s=%0d grant=%0d led=%0d want grant=24 led=8", s, hi, led_hi);
      end
      lo = 0;
      while (GRANT !== 4'b0001 && lo < 100) begin
        step();
        lo++;
      end
      n_checks++;
      if (lo !== 1) begin
        n_fail++;
        $display("FAIL persist_idle s=%0d got=%0d want=1", s, lo);
      end
    end
    REQ = '0;
    n = 0;
    do begin
      step();
      n++;
    end while (BUSY !== 1'b0 && n < 100);
    n_checks++;
    if (BUSY !== 1'b0) begin
      n_fail++;
      $display("FAIL persist_drain got BUSY=%b want 0 within 100 cycles", BUSY);
    end
  endtask

  task automatic test_reset_mid();
    int n, pulses;
    logic prev;
    REQ = 4'b0100;
    n = 0;
    do begin
      step();
      n++;
    end while (GRANT !== 4'b0100 && n < 100);
    for (int c = 0; c < 14; c++) step();
    n_checks++;
    if (LED_OUT !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_second_on got=%b want=1", LED_OUT);
    end
    RESET = 1'b1;
    step();
    n_checks++;
    if (obs_vec !== 14'b0) begin
      n_fail++;
      $display("FAIL mid_reset got=%b want=%b", obs_vec, 14'b0);
    end
    RESET = 1'b0;
    step();
    n_checks++;
    if ({GRANT, BUSY, LED_OUT} !== {4'b0100, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL mid_restart got=%b want=%b", {GRANT, BUSY, LED_OUT}, 6'b010011);
    end
    n = 0; pulses = 1; prev = LED_OUT;
    do begin
      step();
      n++;
      if (n == 1) REQ = '0;
      n_checks++;
      if (obs_vec !== exp_vec) begin
        n_fail++;
        $display("FAIL mid_seq cyc=%0d got=%b want=%b", n, obs_vec, exp_vec);
      end
      if (LED_OUT === 1'b1 && prev === 1'b0) pulses++;
      prev = LED_OUT;
    end while (GRANT === 4'b0100 && n < 200);
    n_checks++;
    if (n !== 48 || pulses !== 3) begin
      n_fail++;
      $display("FAIL mid_fresh len=%0d pulses=%0d want len=48 pulses=3", n, pulses);
    end
  endtask

  task automatic test_random();
    int hold;
    for (int k = 0; k < 60; k++) begin
      if ($urandom_range(0, 3) == 0) REQ = '0;
      else REQ = NR'($urandom_range(0, 15));
      if ($urandom_range(0, 19) == 0) RESET = 1'b1;
      hold = $urandom_range(1, 60);
      for (int c = 0; c < hold; c++) begin
        step();
        RESET = 1'b0;
        n_checks++;
        if (obs_vec !== exp_vec) begin
          n_fail++;
          $display("FAIL random k=%0d cyc=%0d req=%b got=%b want=%b", k, c, REQ, obs_vec, exp_vec);
        end
      end
    end
    REQ = '0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_priority();
    test_persistent();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
